// File: rtl/mod_counter.sv
// Modulo-N up/down counter with synchronous clear/load and a terminal-count flag.
// Runs free with a wrap pulse, or in one-shot mode halts at terminal count until cleared or loaded.
module mod_counter #(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256,
    parameter int     ONESHOT = 0
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    // MODULUS may equal 2**WIDTH, so the load range check needs one extra bit.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] up_val, dn_val, load_sat;

    assign at_max  = (count == MAX_VAL);
    assign at_zero = (count == '0);
    assign tc      = dir ? at_max : at_zero;

    // Terminal values are special-cased so the step never leaves WIDTH bits.
    assign up_val   = at_max  ? '0      : count + 1'b1;
    assign dn_val   = at_zero ? MAX_VAL : count - 1'b1;
    assign load_sat = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        state_nxt = state;
        if (clr) begin
            count_nxt = '0;
            state_nxt = RUN;
        end else if (load) begin
            count_nxt = load_sat;
            state_nxt = RUN;
        end else if (en && state == RUN) begin
            if (ONESHOT != 0 && tc) begin
                state_nxt = HALT;
            end else begin
                count_nxt = dir ? up_val : dn_val;
                wrap_nxt  = tc;
            end
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            state <= RUN;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            state <= state_nxt;
        end
    end

    assign done = (state == HALT);

endmodule

// File: tb/tb_mod_counter.sv
// Drives three counter configurations with shared directed and random stimulus,
// checking every output against a modular-arithmetic reference model.
module tb_mod_counter;

    localparam int N = 3;
    localparam int MODS [N] = '{10, 10, 16};
    localparam int ONES [N] = '{0, 1, 0};

    logic       c, rst_n, en, clr, load, dir;
    logic [3:0] load_val;
    logic [3:0] cnt_o [N];
    logic       tc_o [N], wrap_o [N], done_o [N];

    int mc [N];
    int mw [N];
    int mh [N];
    int tests, fails;

    mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(0)) u_free (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .done(done_o[0]));
    mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1)) u_once (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .done(done_o[1]));
    mod_counter #(.WIDTH(4), .MODULUS(16), .ONESHOT(0)) u_full (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .done(done_o[2]));

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mc[i] = 0; mw[i] = 0; mh[i] = 0;
        end
    endtask

    // One clock edge of the behavioural rules for every configuration.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int m;
            bit term;
            m = MODS[i];
            term = dir ? (mc[i] == m - 1) : (mc[i] == 0);
            mw[i] = 0;
            if (clr) begin
                mc[i] = 0; mh[i] = 0;
            end else if (load) begin
                mc[i] = (int'(load_val) < m) ? int'(load_val) : m - 1;
                mh[i] = 0;
            end else if (en && mh[i] == 0) begin
                if (ONES[i] != 0 && term) mh[i] = 1;
                else begin
                    mc[i] = dir ? (mc[i] + 1) % m : (mc[i] + m - 1) % m;
                    mw[i] = term ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            int m;
            int exp_tc;
            m = MODS[i];
            exp_tc = dir ? int'(mc[i] == m - 1) : int'(mc[i] == 0);
            chk($sformatf("%s.u%0d.count", tag, i), int'(cnt_o[i]), mc[i]);
            chk($sformatf("%s.u%0d.tc", tag, i), int'(tc_o[i]), exp_tc);
            chk($sformatf("%s.u%0d.wrap", tag, i), int'(wrap_o[i]), mw[i]);
            chk($sformatf("%s.u%0d.done", tag, i), int'(done_o[i]), mh[i]);
        end
    endtask

    task automatic step(input string tag);
        @(posedge c);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic e, input logic cl, input logic ld,
                         input logic [3:0] lv, input logic d);
        en = e; clr = cl; load = ld; load_val = lv; dir = d;
    endtask

    initial begin
        tests = 0; fails = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 1);
        #2;
        check_all("reset");
        for (int k = 0; k < 12; k++) step("reset_hold");
        @(negedge c);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) step("count_up");

        drive(0, 0, 1, 4'd3, 0);
        step("load3");
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step("count_down");

        drive(0, 0, 1, 4'd12, 1);
        step("load_sat");
        drive(1, 1, 1, 4'd5, 1);
        step("clr_over_load");

        drive(1, 0, 0, 0, 1);
        for (int k = 0; k < 15; k++) step("oneshot_run");
        drive(0, 0, 0, 0, 0);
        step("halt_ignores_dir");
        drive(1, 0, 0, 0, 0);
        step("halt_ignores_en");
        drive(0, 0, 1, 4'd2, 1);
        step("oneshot_reload");

        drive(1, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) step("to_six");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        rst_n = 1'b1;
        step("after_reset");

        drive(0, 0, 1, 4'd15, 1);
        step("load15");
        drive(1, 0, 0, 0, 1);
        step("full_wrap_up");
        drive(1, 0, 0, 0, 0);
        step("full_wrap_down");
        drive(0, 0, 0, 0, 0);
        step("idle_hold");

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
